alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL: clk  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL: flush  input  1  synchronous discard of all buffered operations.
REQ-004 SHALL: in_valid  input  1  decode presents an operation.
REQ-005 SHALL: in_ready  output  1  block can accept an operation this cycle.
REQ-006 SHALL: in_op  input  5  ALU operation code, using the codes from aluops.vh.
REQ-007 SHALL: in_rs1, in_rs2, in_rd  input  5 each  source and destination register indices.
REQ-008 SHALL: in_r1, in_r2  input  32 each  register-file operand values.
REQ-009 SHALL: in_imm  input  32  immediate; in_use_imm  input  1  selects in_imm as second operand.
REQ-010 SHALL: wb_valid  input  1, wb_rd  input  5, wb_data  input  32  writeback port, used for forwarding.
REQ-011 SHALL: out_valid  output  1  operation presented to the ALU.
REQ-012 SHALL: out_ready  input  1  downstream consumes the ALU result this cycle.
REQ-013 SHALL: alu_op  output  5, r1  output  32, r2  output  32, out_rd  output  5  registered operation to the ALU.

Function
REQ-014 SHALL: implement a 2-entry in-order buffer with states EMPTY, ONE and FULL; outputs are driven only from the head entry.
REQ-015 SHALL: transfer on input when in_valid && in_ready; transfer on output when out_valid && out_ready.
REQ-016 SHALL: in_ready = (state != FULL), driven combinationally from state only and independent of in_valid.
REQ-017 SHALL: out_valid = (state != EMPTY), driven from registers only.
REQ-018 SHALL: latency is 1 cycle: an operation accepted in cycle N is visible on the outputs in cycle N+1 when the buffer was EMPTY, or when it was ONE and drained in cycle N.
REQ-019 SHALL: state transitions are:
- EMPTY+in -> ONE.
- ONE+in+out -> ONE, with the new entry at the head.
- ONE+in -> FULL.
- ONE+out -> EMPTY.
- FULL+out -> ONE, with the tail promoted to head.
- Any other combination holds the current state.
REQ-020 SHALL: FULL+out ignores in_valid, because in_ready is 0.
REQ-021 SHALL: hold alu_op, r1, r2 and out_rd stable while out_valid && !out_ready.
REQ-022 SHALL: capture the stored second operand as in_imm when in_use_imm=1, otherwise in_r2; the use_imm flag is stored per entry.
REQ-023 SHALL: when flush is high, set state to EMPTY next cycle; flush has priority over a simultaneous input or output transfer, and the input is discarded.
REQ-024 SHALL: zero the head entry fields when state becomes EMPTY, so alu_op=0, r1=0, r2=0 and out_rd=0 while out_valid=0.

Reset
REQ-025 SHALL: on rst assertion, immediately force state=EMPTY; out_valid=0; in_ready=1; alu_op, r1, r2 and out_rd = 0; both entries = 0.
REQ-026 SHALL: on rst asserted mid-operation, lose all buffered operations; the first accept is allowed on the first rising edge after deassertion.

Configuration
REQ-027 SHALL: macro FWD_EN enables writeback forwarding.
REQ-028 SHALL, with FWD_EN defined:
- At capture, replace in_r1 by wb_data if wb_valid && wb_rd!=0 && wb_rd==in_rs1.
- At capture, replace in_r2 likewise (matching in_rs2) unless in_use_imm=1.
- Each cycle, update buffered entries whose matching operand (rs1, or rs2 without use_imm) equals a valid, nonzero wb_rd with wb_data.
- Operand registers thereby update while the head is stalled.
REQ-029 SHALL: with FWD_EN undefined, ignore the wb_* ports and capture operands exactly as presented; the hazard-free guarantee is the decoder's responsibility.

Verification
REQ-030 SHALL: reset, then in_op=ADD, in_r1=5, in_r2=7, in_rd=3 for 1 cycle with out_ready=1 -> next cycle out_valid=1, r1=5, r2=7, out_rd=3; the cycle after, out_valid=0.
REQ-031 SHALL: out_ready=0 with 3 back-to-back inputs (r1=1,2,3) -> in_ready=0 after the 2nd accept; raising out_ready then drains r1=1 then 2, with no loss or reorder.
REQ-032 SHALL: in_use_imm=1, in_imm=0xFFFFFFF0, in_r2=9 -> r2=0xFFFFFFF0.
REQ-033 SHALL (FWD_EN): head stalled with rs1=4, r1=0; wb_valid=1, wb_rd=4, wb_data=0x1234 -> next cycle r1=0x1234.
REQ-034 SHALL (FWD_EN): wb_rd=0 with wb_data=0xDEAD and in_rs1=0 -> r1 unchanged.
REQ-035 SHALL: FULL buffer with flush=1 and in_valid=1 -> next cycle out_valid=0, in_ready=1, outputs zero; rst pulse asserted mid-drain -> outputs zero without waiting for a clock edge.

Source files
------------

// File: rtl/alu_issue.sv
// ---------------------------------------------------------------------------
// alu_issue
//   Two-entry in-order issue buffer between decode and the ALU. Operations are
//   captured from decode, held in a head/tail pair and presented to the ALU
//   from the head entry only. All ALU-facing outputs come straight from flops.
//
//   Optional feature (compile-time macro FWD_EN):
//     When defined, writeback results are forwarded into operands both at
//     capture and while entries sit in the buffer. When undefined, the wb_*
//     ports are ignored and operands are captured exactly as presented.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   flush                    synchronous discard of all buffered operations
//   in_valid / in_ready      decode handshake
//   in_op, in_rs1, in_rs2,
//   in_rd                    operation code and register indices
//   in_r1, in_r2, in_imm,
//   in_use_imm               operand values; in_use_imm selects in_imm
//   wb_valid, wb_rd, wb_data writeback port (forwarding source)
//   out_valid / out_ready    ALU handshake
//   alu_op, r1, r2, out_rd   head-entry operation presented to the ALU
//
// States
//   ST_EMPTY | no operation buffered, head fields held at zero
//   ST_ONE   | head valid, tail unused (zero)
//   ST_FULL  | head and tail valid, decode is back-pressured
// ---------------------------------------------------------------------------
module alu_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_r1,
    input  logic [31:0] in_r2,
    input  logic [31:0] in_imm,
    input  logic        in_use_imm,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  alu_op,
    output logic [31:0] r1,
    output logic [31:0] r2,
    output logic [4:0]  out_rd
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef struct packed {
        logic [4:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        use_imm;
    } entry_t;

    logic [1:0] state_q, state_d;
    entry_t     head_q, head_d;
    entry_t     tail_q, tail_d;

    entry_t     head_f;
    entry_t     tail_f;
    entry_t     new_e;
    logic       in_fire;
    logic       out_fire;

`ifdef FWD_EN
    // rs 0 is hardwired zero, so a writeback to it never forwards.
    function automatic logic wb_hit(input logic [4:0] rs);
        return wb_valid && (wb_rd != 5'd0) && (wb_rd == rs);
    endfunction

    function automatic entry_t fwd_entry(input entry_t e);
        entry_t f;
        f = e;
        if (wb_hit(e.rs1)) begin
            f.r1 = wb_data;
        end
        if (!e.use_imm && wb_hit(e.rs2)) begin
            f.r2 = wb_data;
        end
        return f;
    endfunction
`else
    logic unused_wb;
    assign unused_wb = ^{wb_valid, wb_rd, wb_data};
`endif

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        new_e.op      = in_op;
        new_e.rs1     = in_rs1;
        new_e.rs2     = in_rs2;
        new_e.rd      = in_rd;
        new_e.r1      = in_r1;
        new_e.r2      = in_use_imm ? in_imm : in_r2;
        new_e.use_imm = in_use_imm;
`ifdef FWD_EN
        new_e  = fwd_entry(new_e);
        // Buffered entries pick up writebacks every cycle, including while
        // the head is stalled; entries that move this cycle move updated.
        head_f = fwd_entry(head_q);
        tail_f = fwd_entry(tail_q);
`else
        head_f = head_q;
        tail_f = tail_q;
`endif
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_f;
        tail_d  = tail_f;
        if (flush) begin
            state_d = ST_EMPTY;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        head_d  = new_e;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        head_d = new_e;
                    end else if (in_fire) begin
                        state_d = ST_FULL;
                        tail_d  = new_e;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                        head_d  = '0;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so no capture can coincide.
                    if (out_fire) begin
                        state_d = ST_ONE;
                        head_d  = tail_f;
                        tail_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    head_d  = '0;
                    tail_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign alu_op = head_q.op;
    assign r1     = head_q.r1;
    assign r2     = head_q.r2;
    assign out_rd = head_q.rd;

endmodule

// File: tb/tb_alu_issue.sv
// ---------------------------------------------------------------------------
// tb_alu_issue
//   Scoreboard bench for alu_issue. Stimulus pushes the expected operation
//   into a queue when decode's transfer is known to be accepted; a monitor on
//   the falling edge compares the DUT's head against the queue front, checks
//   the handshake outputs against the queue occupancy and pops on transfers.
//   Build with +define+FWD_EN to also exercise writeback forwarding.
// ---------------------------------------------------------------------------
`timescale 1ns/100ps
module tb_alu_issue;

    localparam logic [4:0] OP_ADD = 5'd1;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op, in_rs1, in_rs2, in_rd;
    logic [31:0] in_r1, in_r2, in_imm;
    logic        in_use_imm;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  alu_op;
    logic [31:0] r1, r2;
    logic [4:0]  out_rd;

    alu_issue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_r1(in_r1), .in_r2(in_r2), .in_imm(in_imm), .in_use_imm(in_use_imm),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_op(alu_op), .r1(r1), .r2(r2), .out_rd(out_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] r1;
        logic [31:0] r2;
        bit          use_imm;
    } exp_t;

    exp_t        q[$];
    bit          ready_exp = 1'b1;
    bit          prev_stall = 1'b0;
    logic [73:0] prev_bus;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [73:0] bus_now();
        return {alu_op, r1, r2, out_rd};
    endfunction

    function automatic logic [73:0] bus_of(input exp_t e);
        return {e.op, e.r1, e.r2, e.rd};
    endfunction

    task automatic chk(input string name, input logic [73:0] act, input logic [73:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit fwd_hit(input logic [4:0] rs);
        return wb_valid && wb_rd != 5'd0 && wb_rd == rs;
    endfunction

    // Expected content of a freshly accepted operation.
    function automatic exp_t capture();
        exp_t e;
        e.op = in_op; e.rs1 = in_rs1; e.rs2 = in_rs2; e.rd = in_rd;
        e.use_imm = in_use_imm;
        e.r1 = in_r1;
        e.r2 = in_use_imm ? in_imm : in_r2;
`ifdef FWD_EN
        if (fwd_hit(in_rs1)) e.r1 = wb_data;
        if (!in_use_imm && fwd_hit(in_rs2)) e.r2 = wb_data;
`endif
        return e;
    endfunction

    // Monitor: compare and consume on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            ready_exp = (q.size() < 2);
            chk("in_ready", {73'd0, in_ready}, {73'd0, ready_exp});
            chk("out_valid", {73'd0, out_valid}, {73'd0, q.size() != 0});
            if (q.size() == 0) begin
                chk("empty_bus_zero", bus_now(), 74'd0);
            end else begin
                chk("head", bus_now(), bus_of(q[0]));
            end
`ifndef FWD_EN
            if (prev_stall && out_valid) chk("stall_stable", bus_now(), prev_bus);
`endif
            prev_stall = (q.size() != 0) && !out_ready && !flush;
            prev_bus   = bus_now();
            if (flush) begin
                q.delete();
            end else if (q.size() != 0 && out_ready) begin
                void'(q.pop_front());
            end
`ifdef FWD_EN
            foreach (q[i]) begin
                if (fwd_hit(q[i].rs1)) q[i].r1 = wb_data;
                if (!q[i].use_imm && fwd_hit(q[i].rs2)) q[i].r2 = wb_data;
            end
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus side: push when this cycle's offer is accepted.
    task automatic settle();
        @(negedge clk);
        #1;
        if (in_valid && ready_exp && !flush) q.push_back(capture());
    endtask

    task automatic set_idle();
        in_valid = 1'b0; flush = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        in_op = OP_ADD; in_rs1 = 5'd1; in_rs2 = 5'd2; in_rd = 5'd0;
        in_r1 = 32'd0; in_r2 = 32'd0; in_imm = 32'd0; in_use_imm = 1'b0;
    endtask

    task automatic cyc(input bit v, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit ordy);
        tick();
        set_idle();
        in_valid = v; in_r1 = a; in_r2 = b; in_rd = rd; out_ready = ordy;
        settle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        set_idle();
        #2;
        chk("reset_in_ready", {73'd0, in_ready}, 74'd1);
        chk("reset_out_valid", {73'd0, out_valid}, 74'd0);
        chk("reset_bus", bus_now(), 74'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single op, one-cycle latency, then empty.
        cyc(1, 32'd5, 32'd7, 5'd3, 1);
        cyc(0, 0, 0, 0, 1);
        chk("lat_valid", {73'd0, out_valid}, 74'd1);
        chk("lat_bus", bus_now(), {OP_ADD, 32'd5, 32'd7, 5'd3});
        cyc(0, 0, 0, 0, 1);
        chk("lat_empty", {73'd0, out_valid}, 74'd0);

        // Back-pressure with three offers, then in-order drain.
        cyc(1, 32'd1, 32'd0, 5'd4, 0);
        cyc(1, 32'd2, 32'd0, 5'd5, 0);
        cyc(1, 32'd3, 32'd0, 5'd6, 0);
        chk("full_not_ready", {73'd0, in_ready}, 74'd0);
        cyc(0, 0, 0, 0, 1);
        chk("drain_first", {42'd0, r1}, 74'd1);
        cyc(0, 0, 0, 0, 1);
        chk("drain_second", {42'd0, r1}, 74'd2);
        cyc(0, 0, 0, 0, 1);
        chk("drain_empty", {73'd0, out_valid}, 74'd0);

        // Immediate selects the second operand.
        tick();
        set_idle();
        in_valid = 1; in_use_imm = 1; in_imm = 32'hFFFF_FFF0; in_r2 = 32'd9; in_rd = 5'd7;
        out_ready = 0;
        settle();
        cyc(0, 0, 0, 0, 1);
        chk("imm_r2", {42'd0, r2}, {42'd0, 32'hFFFF_FFF0});
        cyc(0, 0, 0, 0, 1);

        // Flush of a full buffer beats a simultaneous offer.
        cyc(1, 32'hA, 32'hB, 5'd1, 0);
        cyc(1, 32'hC, 32'hD, 5'd2, 0);
        tick();
        set_idle();
        flush = 1; in_valid = 1; in_r1 = 32'hE; out_ready = 1;
        settle();
        cyc(0, 0, 0, 0, 0);
        chk("flush_valid", {73'd0, out_valid}, 74'd0);
        chk("flush_ready", {73'd0, in_ready}, 74'd1);
        chk("flush_bus", bus_now(), 74'd0);

        // Asynchronous reset mid-drain.
        cyc(1, 32'd10, 32'd1, 5'd1, 0);
        cyc(1, 32'd11, 32'd2, 5'd2, 0);
        cyc(0, 0, 0, 0, 1);
        tick();
        set_idle();
        out_ready = 1;
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", {73'd0, out_valid}, 74'd0);
        chk("async_rst_ready", {73'd0, in_ready}, 74'd1);
        chk("async_rst_bus", bus_now(), 74'd0);
        q.delete();
        prev_stall = 1'b0;
        ready_exp = 1'b1;
        #1 rst = 1'b0;
        cyc(1, 32'd20, 32'd21, 5'd5, 1);
        cyc(0, 0, 0, 0, 1);
        chk("post_rst_accept", {42'd0, r1}, 74'd20);

`ifdef FWD_EN
        // Stalled head picks up a writeback to its rs1.
        tick();
        set_idle();
        in_valid = 1; in_rs1 = 5'd4; in_r1 = 32'd0; in_rd = 5'd9; out_ready = 0;
        settle();
        tick();
        set_idle();
        wb_valid = 1; wb_rd = 5'd4; wb_data = 32'h1234; out_ready = 0;
        settle();
        cyc(0, 0, 0, 0, 0);
        chk("fwd_stalled_r1", {42'd0, r1}, {42'd0, 32'h1234});
        cyc(0, 0, 0, 0, 1);
        // Writeback to register zero never forwards.
        tick();
        set_idle();
        in_valid = 1; in_rs1 = 5'd0; in_r1 = 32'h55; wb_valid = 1; wb_rd = 5'd0;
        wb_data = 32'hDEAD; out_ready = 0;
        settle();
        cyc(0, 0, 0, 0, 0);
        chk("fwd_rd0_r1", {42'd0, r1}, {42'd0, 32'h55});
        cyc(0, 0, 0, 0, 1);
`endif

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            tick();
            set_idle();
            in_valid   = ($urandom_range(0, 9) < 7);
            out_ready  = ($urandom_range(0, 9) < 6);
            flush      = ($urandom_range(0, 99) < 3);
            in_op      = 5'($urandom);
            in_rs1     = 5'($urandom_range(0, 5));
            in_rs2     = 5'($urandom_range(0, 5));
            in_rd      = 5'($urandom);
            in_r1      = $urandom;
            in_r2      = $urandom;
            in_imm     = $urandom;
            in_use_imm = ($urandom_range(0, 9) < 3);
            wb_valid   = ($urandom_range(0, 1) == 1);
            wb_rd      = 5'($urandom_range(0, 5));
            wb_data    = $urandom;
            settle();
        end

        // Bounded drain.
        for (int n = 0; n < 6; n++) cyc(0, 0, 0, 0, 1);
        chk("final_drained", {42'd0, 32'(q.size())}, 74'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
